// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: immediate-generator mode encodings and the
// instruction-field positions each immediate format is taken from.
package legv8_pkg;

    localparam logic [2:0] IMM_B    = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_D    = 3'b010;
    localparam logic [2:0] IMM_CB   = 3'b011;
    localparam logic [2:0] IMM_MOVZ = 3'b100;

    localparam int B_MSB    = 25;
    localparam int B_LSB    = 0;
    localparam int I_MSB    = 21;
    localparam int I_LSB    = 10;
    localparam int D_MSB    = 20;
    localparam int D_LSB    = 12;
    localparam int CB_MSB   = 23;
    localparam int CB_LSB   = 5;
    localparam int MOVZ_MSB = 20;
    localparam int MOVZ_LSB = 5;
    localparam int HW_MSB   = 22;
    localparam int HW_LSB   = 21;

    localparam int B_W    = B_MSB - B_LSB + 1;
    localparam int I_W    = I_MSB - I_LSB + 1;
    localparam int D_W    = D_MSB - D_LSB + 1;
    localparam int CB_W   = CB_MSB - CB_LSB + 1;
    localparam int MOVZ_W = MOVZ_MSB - MOVZ_LSB + 1;

    localparam int TAG_W = 8;
    localparam int CNT_W = 16;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: selects, extends and shifts the field
// named by ctrl; reserved encodings yield zero and flag illegal.
module imm_decode
    import legv8_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 2
) (
    input  logic [25:0]       imm26,
    input  logic [2:0]        ctrl,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);

    logic [DATA_W-1:0] b_ext;
    logic [DATA_W-1:0] i_ext;
    logic [DATA_W-1:0] d_ext;
    logic [DATA_W-1:0] cb_ext;
    logic [DATA_W-1:0] movz_ext;
    logic [5:0]        movz_sh;

    assign b_ext    = {{(DATA_W-B_W){imm26[B_MSB]}}, imm26[B_MSB:B_LSB]};
    assign i_ext    = {{(DATA_W-I_W){1'b0}}, imm26[I_MSB:I_LSB]};
    assign d_ext    = {{(DATA_W-D_W){imm26[D_MSB]}}, imm26[D_MSB:D_LSB]};
    assign cb_ext   = {{(DATA_W-CB_W){imm26[CB_MSB]}}, imm26[CB_MSB:CB_LSB]};
    assign movz_ext = {{(DATA_W-MOVZ_W){1'b0}}, imm26[MOVZ_MSB:MOVZ_LSB]};
    // hw*16; shifting at or past DATA_W clears the result (MOVZ hw=3 at 32 bits)
    assign movz_sh  = {imm26[HW_MSB:HW_LSB], 4'b0000};

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (ctrl)
            IMM_B:    imm = b_ext << BR_SHIFT;
            IMM_I:    imm = i_ext;
            IMM_D:    imm = d_ext;
            IMM_CB:   imm = cb_ext << BR_SHIFT;
            IMM_MOVZ: imm = movz_ext << movz_sh;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined LEGv8 immediate generator: decode on accept, then a small
// circular output buffer with valid/ready handshakes on both sides.
module imm_extend_pipe
    import legv8_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int BR_SHIFT  = 2,
    parameter int BUF_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [25:0]       Imm26,
    input  logic [2:0]        Ctrl,
    input  logic [TAG_W-1:0]  InTag,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] BusImm,
    output logic [TAG_W-1:0]  OutTag,
    output logic              IllegalOp,
    output logic [CNT_W-1:0]  IllegalCnt
);

    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_DEPTH);

    logic [DATA_W-1:0] dec_imm;
    logic              dec_illegal;

    logic [DATA_W-1:0] imm_mem [BUF_DEPTH];
    logic [TAG_W-1:0]  tag_mem [BUF_DEPTH];
    logic              ill_mem [BUF_DEPTH];

    logic [OCC_W-1:0]  count_reg, count_next, remain;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [DATA_W-1:0] bus_imm_reg, bus_imm_next;
    logic [TAG_W-1:0]  out_tag_reg, out_tag_next;
    logic              illegal_op_reg, illegal_op_next;
    logic [CNT_W-1:0]  illegal_cnt_reg, illegal_cnt_next;
    logic              push, pop;

    imm_decode #(
        .DATA_W  (DATA_W),
        .BR_SHIFT(BR_SHIFT)
    ) u_decode (
        .imm26  (Imm26),
        .ctrl   (Ctrl),
        .imm    (dec_imm),
        .illegal(dec_illegal)
    );

    assign OutValid   = (count_reg != '0);
    assign pop        = OutValid & OutReady;
    // A pop frees a slot this cycle, so a full buffer can still take an input.
    assign InReady    = (count_reg < FULL) | pop;
    assign push       = InValid & InReady;

    assign BusImm     = bus_imm_reg;
    assign OutTag     = out_tag_reg;
    assign IllegalOp  = illegal_op_reg;
    assign IllegalCnt = illegal_cnt_reg;

    always_comb begin
        count_next       = count_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        illegal_cnt_next = illegal_cnt_reg;
        bus_imm_next     = bus_imm_reg;
        out_tag_next     = out_tag_reg;
        illegal_op_next  = illegal_op_reg;

        if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_next = count_reg + OCC_W'(1);
            2'b01:   count_next = count_reg - OCC_W'(1);
            default: count_next = count_reg;
        endcase

        if (push && dec_illegal && (illegal_cnt_reg != {CNT_W{1'b1}}))
            illegal_cnt_next = illegal_cnt_reg + CNT_W'(1);

        // Entries already stored that survive this cycle's pop; if none remain,
        // the incoming result (if any) becomes the new head directly.
        remain = pop ? (count_reg - OCC_W'(1)) : count_reg;
        if (remain != '0) begin
            bus_imm_next    = imm_mem[rd_ptr_next];
            out_tag_next    = tag_mem[rd_ptr_next];
            illegal_op_next = ill_mem[rd_ptr_next];
        end else if (push) begin
            bus_imm_next    = dec_imm;
            out_tag_next    = InTag;
            illegal_op_next = dec_illegal;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            imm_mem[wr_ptr_reg] <= dec_imm;
            tag_mem[wr_ptr_reg] <= InTag;
            ill_mem[wr_ptr_reg] <= dec_illegal;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            bus_imm_reg     <= '0;
            out_tag_reg     <= '0;
            illegal_op_reg  <= 1'b0;
            illegal_cnt_reg <= '0;
        end else begin
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            bus_imm_reg     <= bus_imm_next;
            out_tag_reg     <= out_tag_next;
            illegal_op_reg  <= illegal_op_next;
            illegal_cnt_reg <= illegal_cnt_next;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed immediate vectors, back-pressure and
// reset cases, plus a randomized run against a queue-based reference model.
module tb_imm_extend_pipe;

    localparam int DW  = 64;
    localparam int BRS = 2;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [25:0]   Imm26 = '0;
    logic [2:0]    Ctrl = '0;
    logic [7:0]    InTag = '0;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [DW-1:0] BusImm;
    logic [7:0]    OutTag;
    logic          IllegalOp;
    logic [15:0]   IllegalCnt;

    always #5 CLK = ~CLK;

    imm_extend_pipe #(.DATA_W(DW), .BR_SHIFT(BRS), .BUF_DEPTH(2)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .Imm26     (Imm26),
        .Ctrl      (Ctrl),
        .InTag     (InTag),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .BusImm    (BusImm),
        .OutTag    (OutTag),
        .IllegalOp (IllegalOp),
        .IllegalCnt(IllegalCnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: field value as an integer, sign-adjusted, scaled by powers of two.
    function automatic logic [63:0] ref_imm(input logic [25:0] f, input logic [2:0] c);
        longint    ff = longint'(f);
        longint    v;
        logic [63:0] u;
        longint    hw;
        case (c)
            3'd0: begin
                v = ff;
                if (v >= (longint'(1) << 25)) v = v - (longint'(1) << 26);
                return 64'(v * (longint'(1) << BRS));
            end
            3'd1: return 64'((ff / 1024) % 4096);
            3'd2: begin
                v = (ff / 4096) % 512;
                if (v >= 256) v = v - 512;
                return 64'(v);
            end
            3'd3: begin
                v = (ff / 32) % 524288;
                if (v >= 262144) v = v - 524288;
                return 64'(v * (longint'(1) << BRS));
            end
            3'd4: begin
                u  = 64'((ff / 32) % 65536);
                hw = (ff / 2097152) % 4;
                for (longint k = 0; k < hw; k++) u = u * 64'd65536;
                return u;
            end
            default: return 64'd0;
        endcase
    endfunction

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   ill_model = 0;

    // Scoreboard: sample at negedge, transfers then occur at the following posedge.
    initial begin
        logic        stall_prev = 1'b0;
        logic [63:0] imm_prev = '0;
        logic [7:0]  tag_prev = '0;
        logic        ill_prev = 1'b0;
        exp_t        e;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                q.delete();
                ill_model  = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", OutValid, 1);
                    check("stall_imm", BusImm, imm_prev);
                    check("stall_tag", OutTag, tag_prev);
                    check("stall_ill", IllegalOp, ill_prev);
                end
                check("valid_vs_model", OutValid, q.size() != 0);
                check("inready_vs_model", InReady, (q.size() < 2) || (OutValid && OutReady));
                check("illcnt", IllegalCnt, ill_model);
                if (OutValid && OutReady) begin
                    if (q.size() == 0) begin
                        check("pop_nonempty", 0, 1);
                    end else begin
                        e = q.pop_front();
                        check("out_imm", BusImm, e.imm);
                        check("out_tag", OutTag, e.tag);
                        check("out_ill", IllegalOp, e.ill);
                    end
                end
                if (InValid && InReady) begin
                    e.imm = ref_imm(Imm26, Ctrl);
                    e.tag = InTag;
                    e.ill = (Ctrl >= 3'd5);
                    q.push_back(e);
                    if (Ctrl >= 3'd5 && ill_model < 65535) ill_model++;
                end
                stall_prev = OutValid && !OutReady;
                imm_prev   = BusImm;
                tag_prev   = OutTag;
                ill_prev   = IllegalOp;
            end
        end
    end

    // Called #1 after a posedge with the buffer empty; leaves #1 after a posedge.
    task automatic send(input logic [2:0] c, input logic [25:0] f, input logic [7:0] t,
                        input logic [63:0] exp, input logic exp_ill, input string nm);
        InValid = 1'b1; Ctrl = c; Imm26 = f; InTag = t; OutReady = 1'b1;
        @(posedge CLK); #1;
        InValid = 1'b0;
        @(negedge CLK);
        check({nm, "_imm"}, BusImm, exp);
        check({nm, "_valid"}, OutValid, 1);
        check({nm, "_tag"}, OutTag, t);
        check({nm, "_ill"}, IllegalOp, exp_ill);
        $display("send %s ctrl=%0d imm26=%h -> BusImm=%h tag=%0d", nm, c, f, BusImm, OutTag);
        @(posedge CLK); #1;
    endtask

    initial begin
        #2 Reset = 1'b1;
        #1;
        check("rst_valid", OutValid, 0);
        check("rst_imm", BusImm, 0);
        check("rst_tag", OutTag, 0);
        check("rst_ill", IllegalOp, 0);
        check("rst_cnt", IllegalCnt, 0);
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;

        send(3'b000, 26'b1010, 8'd10, 64'h28, 1'b0, "b_pos");
        send(3'b011, 26'h3BBD0F9, 8'd11,
             {{43{1'b1}}, 19'b1011101111010000111, 2'b00}, 1'b0, "cb_neg");
        send(3'b001, 26'b11100110111101000011111001, 8'd12, 64'h6F4, 1'b0, "i_ze");
        send(3'b010, 26'b11101110111101000011111001, 8'd13,
             {{55{1'b1}}, 9'h1BD}, 1'b0, "d_neg");
        send(3'b100, {3'b000, 2'b11, 16'hBEEF, 5'b00000}, 8'd14,
             64'hBEEF_0000_0000_0000, 1'b0, "movz_hw3");
        send(3'b101, 26'h155AA55, 8'd15, 64'h0, 1'b1, "reserved");
        check("illcnt_one", IllegalCnt, 1);

        // Back-pressure: tags 1,2,3 with the consumer stalled.
        OutReady = 1'b0; InValid = 1'b1; Ctrl = 3'b001; Imm26 = 26'h0ABCDEF; InTag = 8'd1;
        @(posedge CLK); #1 InTag = 8'd2;
        @(posedge CLK); #1 InTag = 8'd3;
        @(negedge CLK);
        check("full_inready", InReady, 0);
        check("full_head_tag", OutTag, 1);
        @(posedge CLK); #1 OutReady = 1'b1;
        @(negedge CLK);
        check("passthru_inready", InReady, 1);
        @(posedge CLK); #1 InValid = 1'b0;
        @(negedge CLK);
        check("order_2", OutTag, 2);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("order_3", OutTag, 3);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("drained", OutValid, 0);
        check("hold_tag", OutTag, 3);
        $display("backpressure sequence tags 1,2,3 complete");
        @(posedge CLK); #1;

        for (int i = 0; i < 10000; i++) begin
            InValid  = 1'($urandom_range(0, 1));
            OutReady = 1'($urandom_range(0, 1));
            Imm26    = 26'($urandom);
            Ctrl     = 3'($urandom_range(0, 7));
            InTag    = 8'($urandom);
            @(posedge CLK); #1;
        end
        InValid = 1'b0; OutReady = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        $display("random phase done, illegal count model=%0d", ill_model);

        // Reset with two entries buffered.
        OutReady = 1'b0; InValid = 1'b1; Ctrl = 3'b110; InTag = 8'hA5;
        repeat (2) @(posedge CLK);
        #1 InValid = 1'b0;
        check("pre_rst_valid", OutValid, 1);
        Reset = 1'b1;
        #1;
        check("async_rst_valid", OutValid, 0);
        check("async_rst_cnt", IllegalCnt, 0);
        @(posedge CLK); #1 Reset = 1'b0;
        @(negedge CLK);
        check("post_rst_inready", InReady, 1);
        check("post_rst_cnt", IllegalCnt, 0);
        check("post_rst_valid", OutValid, 0);
        $display("reset with buffered entries complete");
        @(posedge CLK); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
